zoom_sequencer: RTL and testbench

ZOOM_SEQUENCER -- requirements
Module: zoom_sequencer

---
 rtl/zoom_pkg.sv | 52 +++++
 rtl/zoom_sequencer_if.sv | 26 ++
 rtl/watchdog_counter.sv | 31 +++
 rtl/zoom_sequencer.sv | 172 +++++++++++++++++
 tb/tb_zoom_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zoom_pkg.sv
// zoom_pkg: shared constants and encodings for the zoom sequencer.
//   - default zoom-level constants (1/8x .. 8x, 1x at LEVEL_BASE_DEF)
//   - scaling-engine mode encoding driven on eng_mode
//   - operator algorithm-select encoding
//   - sequencer FSM state encoding and latched command kind
package zoom_pkg;

  localparam int LEVEL_W        = 3;
  localparam int LEVEL_MIN_DEF  = 0;
  localparam int LEVEL_BASE_DEF = 3;
  localparam int LEVEL_MAX_DEF  = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    MODE_COPY    = 3'd0,
    MODE_NN_IN   = 3'd1,
    MODE_REP_IN  = 3'd2,
    MODE_DEC_OUT = 3'd3,
    MODE_AVG_OUT = 3'd4
  } eng_mode_t;

  // Bit 1 of the algorithm code is the zoom direction (1 = out).
  typedef enum logic [1:0] {
    ALGO_NN_IN   = 2'b00,
    ALGO_REP_IN  = 2'b01,
    ALGO_DEC_OUT = 2'b10,
    ALGO_AVG_OUT = 2'b11
  } algo_t;

  typedef enum logic [1:0] {
    CMD_RETURN   = 2'd0,
    CMD_ZOOM_IN  = 2'd1,
    CMD_ZOOM_OUT = 2'd2
  } cmd_t;

  function automatic eng_mode_t algo_to_mode(input algo_t a);
    case (a)
      ALGO_NN_IN:   return MODE_NN_IN;
      ALGO_REP_IN:  return MODE_REP_IN;
      ALGO_DEC_OUT: return MODE_DEC_OUT;
      default:      return MODE_AVG_OUT;
    endcase
  endfunction

endpackage

// File: rtl/zoom_sequencer_if.sv
// zoom_sequencer_if: handshake between the zoom sequencer and the scaling engine.
//   eng_start        sequencer -> engine  one-cycle start strobe
//   eng_abort        sequencer -> engine  one-cycle abort strobe
//   eng_mode         sequencer -> engine  scaling mode (zoom_pkg::eng_mode_t)
//   eng_target_level sequencer -> engine  zoom level to produce
//   eng_done         engine -> sequencer  one-cycle completion strobe
interface zoom_sequencer_if;
  import zoom_pkg::*;

  logic               eng_start;
  logic               eng_abort;
  logic [2:0]         eng_mode;
  logic [LEVEL_W-1:0] eng_target_level;
  logic               eng_done;

  modport master (
    output eng_start, eng_abort, eng_mode, eng_target_level,
    input  eng_done
  );

  modport slave (
    input  eng_start, eng_abort, eng_mode, eng_target_level,
    output eng_done
  );

endinterface

// File: rtl/watchdog_counter.sv
// watchdog_counter: cycle counter that flags expiry after TIMEOUT_CYCLES counts.
//   clk, rst  clock and asynchronous active-high reset
//   clear     synchronous clear to zero (has priority over enable)
//   enable    count one per cycle
//   expired   high while the count equals TIMEOUT_CYCLES-1
module watchdog_counter #(
  parameter  int TIMEOUT_CYCLES = 1000000,
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

  // Holding at the terminal value keeps expired asserted instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && !expired)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/zoom_sequencer.sv
// zoom_sequencer: accepts operator zoom commands, validates them against the
// selection-error inputs, algorithm direction and level limits, launches the
// scaling engine and reports completion, rejection or timeout.
//   CLOCK_50, POWER_ON_RESET       clock, asynchronous active-high reset
//   cmd_*_pulse                    one-cycle command strobes
//   cmd_algorithm_select           zoom_pkg::algo_t
//   cmd_multiple_sw_error,
//   cmd_no_sw_error                selection-error levels (reject when high)
//   controller_done                one-cycle completion strobe
//   controller_zoom_level          current zoom level
//   cmd_error                      last command rejected or timed out
//   busy                           high whenever not idle
//   eng                            engine handshake (zoom_sequencer_if.master)
module zoom_sequencer
  import zoom_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int LEVEL_BASE     = LEVEL_BASE_DEF,
  parameter int LEVEL_MIN      = LEVEL_MIN_DEF,
  parameter int LEVEL_MAX      = LEVEL_MAX_DEF
) (
  input  logic               CLOCK_50,
  input  logic               POWER_ON_RESET,
  input  logic               cmd_reset_pulse,
  input  logic               cmd_zoom_in_pulse,
  input  logic               cmd_zoom_out_pulse,
  input  logic               cmd_return_pulse,
  input  logic [1:0]         cmd_algorithm_select,
  input  logic               cmd_multiple_sw_error,
  input  logic               cmd_no_sw_error,
  output logic               controller_done,
  output logic [LEVEL_W-1:0] controller_zoom_level,
  output logic               cmd_error,
  output logic               busy,
  zoom_sequencer_if.master   eng
);

  localparam logic [LEVEL_W-1:0] LVL_BASE = LEVEL_W'(LEVEL_BASE);
  localparam logic [LEVEL_W-1:0] LVL_MIN  = LEVEL_W'(LEVEL_MIN);
  localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(LEVEL_MAX);

  state_t             state_q, state_n;
  cmd_t               cmd_q, cmd_n;
  eng_mode_t          mode_q, mode_n;
  logic [LEVEL_W-1:0] tgt_q, tgt_n;
  logic [LEVEL_W-1:0] level_q, level_n;
  logic               err_q, err_n;
  logic               abort;
  logic               reject;
  logic               wd_expired;
  algo_t              algo;

  assign algo = algo_t'(cmd_algorithm_select);

  watchdog_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (CLOCK_50),
    .rst     (POWER_ON_RESET),
    .clear   (state_q != ST_WAIT),
    .enable  (state_q == ST_WAIT),
    .expired (wd_expired)
  );

  always_ff @(posedge CLOCK_50 or posedge POWER_ON_RESET) begin
    if (POWER_ON_RESET)
      state_q <= ST_IDLE;
    else
      state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    cmd_n   = cmd_q;
    mode_n  = mode_q;
    tgt_n   = tgt_q;
    level_n = level_q;
    err_n   = err_q;
    abort   = 1'b0;
    reject  = 1'b0;
    // The operator reset strobe overrides whatever is in flight.
    if (cmd_reset_pulse) begin
      state_n = ST_IDLE;
      level_n = LVL_BASE;
      err_n   = 1'b0;
      abort   = (state_q == ST_WAIT);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_return_pulse) begin
            cmd_n   = CMD_RETURN;
            state_n = ST_CHECK;
          end else if (cmd_zoom_in_pulse) begin
            cmd_n   = CMD_ZOOM_IN;
            state_n = ST_CHECK;
          end else if (cmd_zoom_out_pulse) begin
            cmd_n   = CMD_ZOOM_OUT;
            state_n = ST_CHECK;
          end
        end
        ST_CHECK: begin
          reject = cmd_no_sw_error || cmd_multiple_sw_error ||
                   ((cmd_q == CMD_ZOOM_IN)  && ( algo[1] || (level_q == LVL_MAX))) ||
                   ((cmd_q == CMD_ZOOM_OUT) && (!algo[1] || (level_q == LVL_MIN)));
          if (reject) begin
            state_n = ST_REPORT;
            err_n   = 1'b1;
          end else if ((cmd_q == CMD_RETURN) && (level_q == LVL_BASE)) begin
            state_n = ST_REPORT;
            err_n   = 1'b0;
          end else begin
            state_n = ST_START;
            case (cmd_q)
              CMD_ZOOM_IN: begin
                mode_n = algo_to_mode(algo);
                tgt_n  = level_q + 1'b1;
              end
              CMD_ZOOM_OUT: begin
                mode_n = algo_to_mode(algo);
                tgt_n  = level_q - 1'b1;
              end
              default: begin
                mode_n = MODE_COPY;
                tgt_n  = LVL_BASE;
              end
            endcase
          end
        end
        ST_START: state_n = ST_WAIT;
        ST_WAIT: begin
          // Completion is checked first so it wins over a coincident timeout.
          if (eng.eng_done) begin
            level_n = tgt_q;
            err_n   = 1'b0;
            state_n = ST_REPORT;
          end else if (wd_expired) begin
            abort   = 1'b1;
            err_n   = 1'b1;
            state_n = ST_REPORT;
          end
        end
        ST_REPORT: state_n = ST_IDLE;
        default:   state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge POWER_ON_RESET) begin
    if (POWER_ON_RESET) begin
      cmd_q   <= CMD_RETURN;
      mode_q  <= MODE_COPY;
      tgt_q   <= LVL_BASE;
      level_q <= LVL_BASE;
      err_q   <= 1'b0;
    end else begin
      cmd_q   <= cmd_n;
      mode_q  <= mode_n;
      tgt_q   <= tgt_n;
      level_q <= level_n;
      err_q   <= err_n;
    end
  end

  // A reset strobe landing on START/REPORT suppresses that cycle's strobe.
  assign eng.eng_start          = (state_q == ST_START)  && !cmd_reset_pulse;
  assign controller_done        = (state_q == ST_REPORT) && !cmd_reset_pulse;
  assign eng.eng_abort          = abort;
  assign eng.eng_mode           = mode_q;
  assign eng.eng_target_level   = tgt_q;
  assign controller_zoom_level  = level_q;
  assign cmd_error              = err_q;
  assign busy                   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_zoom_sequencer.sv
// tb_zoom_sequencer: self-checking bench for zoom_sequencer (TIMEOUT_CYCLES=16).
// Directed table, hand-written corner sequences, then randomized commands
// checked against a command-level reference model.
module tb_zoom_sequencer;

  localparam int TO = 16;

  logic       CLOCK_50 = 1'b0;
  logic       POWER_ON_RESET;
  logic       cmd_reset_pulse, cmd_zoom_in_pulse, cmd_zoom_out_pulse, cmd_return_pulse;
  logic [1:0] cmd_algorithm_select;
  logic       cmd_multiple_sw_error, cmd_no_sw_error;
  logic       controller_done, cmd_error, busy;
  logic [2:0] controller_zoom_level;

  zoom_sequencer_if eng_if ();

  zoom_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50              (CLOCK_50),
    .POWER_ON_RESET        (POWER_ON_RESET),
    .cmd_reset_pulse       (cmd_reset_pulse),
    .cmd_zoom_in_pulse     (cmd_zoom_in_pulse),
    .cmd_zoom_out_pulse    (cmd_zoom_out_pulse),
    .cmd_return_pulse      (cmd_return_pulse),
    .cmd_algorithm_select  (cmd_algorithm_select),
    .cmd_multiple_sw_error (cmd_multiple_sw_error),
    .cmd_no_sw_error       (cmd_no_sw_error),
    .controller_done       (controller_done),
    .controller_zoom_level (controller_zoom_level),
    .cmd_error             (cmd_error),
    .busy                  (busy),
    .eng                   (eng_if)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;
  int mdl_level = 3;

  typedef struct {
    int started, mode, tgt, mode_after, done_k, abort_k, err, level, busy_after, done_after;
  } res_t;

  // kind: 0 return, 1 zoom_in, 2 zoom_out, 3 in+out together, 4 return+in together
  typedef struct {
    int         kind;
    logic [1:0] algo;
    bit         nosw, multi;
    int         delay;   // WAIT cycle of eng_done, -1 = engine silent
    int         exp_start, exp_mode, exp_tgt, exp_err, exp_level;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Issues one command and observes it to completion. done_k/abort_k are
  // counted in cycles after the eng_start cycle (0 = done in the t+2 cycle).
  task automatic run_cmd(input int kind, input logic [1:0] algo, input bit nosw, input bit multi,
                         input int delay, input bit noise, output res_t r);
    r = '{default: 0};
    r.done_k  = -1;
    r.abort_k = -1;
    step();
    eng_if.eng_done       = 1'b0;
    cmd_algorithm_select  = algo;
    cmd_no_sw_error       = nosw;
    cmd_multiple_sw_error = multi;
    cmd_return_pulse      = (kind == 0) || (kind == 4);
    cmd_zoom_in_pulse     = (kind == 1) || (kind == 3) || (kind == 4);
    cmd_zoom_out_pulse    = (kind == 2) || (kind == 3);
    step();
    cmd_return_pulse   = 1'b0;
    cmd_zoom_in_pulse  = 1'b0;
    cmd_zoom_out_pulse = 1'b0;
    step();
    #1;
    r.started = int'(eng_if.eng_start);
    r.mode    = int'(eng_if.eng_mode);
    r.tgt     = int'(eng_if.eng_target_level);
    if (controller_done) begin
      r.done_k = 0;
      r.err    = int'(cmd_error);
    end
    if (r.started != 0) begin
      for (int k = 0; k < TO + 8 && r.done_k < 0; k++) begin
        step();
        eng_if.eng_done    = (k == delay);
        cmd_zoom_out_pulse = noise && (k == 0);
        #1;
        if (eng_if.eng_abort && r.abort_k < 0) r.abort_k = k + 1;
        if (controller_done) begin
          r.done_k = k + 1;
          r.err    = int'(cmd_error);
        end
      end
    end
    step();
    eng_if.eng_done    = 1'b0;
    cmd_zoom_out_pulse = 1'b0;
    #1;
    r.busy_after = int'(busy);
    r.done_after = int'(controller_done);
    r.level      = int'(controller_zoom_level);
    r.mode_after = int'(eng_if.eng_mode);
  endtask

  // Command-level reference: outcome follows only from level, command and inputs.
  task automatic exec_model(input string tag, input int kind, input logic [1:0] algo,
                            input bit nosw, input bit multi, input int delay, input bit noise);
    int eff, e_start, e_mode, e_tgt, e_done, e_abort, e_err, e_lvl;
    bit rej;
    res_t r;
    eff = (kind == 3) ? 1 : (kind == 4) ? 0 : kind;
    rej = nosw || multi ||
          (eff == 1 && (algo[1] || mdl_level == 6)) ||
          (eff == 2 && (!algo[1] || mdl_level == 0));
    e_start = 0; e_mode = 0; e_tgt = 0; e_abort = -1; e_done = 0; e_lvl = mdl_level;
    if (rej) e_err = 1;
    else if (eff == 0 && mdl_level == 3) e_err = 0;
    else begin
      e_start = 1;
      e_mode  = (eff == 0) ? 0 : int'(algo) + 1;
      e_tgt   = (eff == 0) ? 3 : (eff == 1) ? mdl_level + 1 : mdl_level - 1;
      if (delay < 0) begin
        e_abort = TO; e_done = TO + 1; e_err = 1;
      end else begin
        e_done = delay + 2; e_err = 0; e_lvl = e_tgt;
      end
    end
    run_cmd(kind, algo, nosw, multi, delay, noise, r);
    check({tag, " started"}, r.started, e_start);
    if (e_start != 0) begin
      check({tag, " mode"}, r.mode, e_mode);
      check({tag, " target"}, r.tgt, e_tgt);
      check({tag, " mode held"}, r.mode_after, e_mode);
    end
    check({tag, " done cycle"}, r.done_k, e_done);
    check({tag, " abort cycle"}, r.abort_k, e_abort);
    check({tag, " error"}, r.err, e_err);
    check({tag, " level"}, r.level, e_lvl);
    check({tag, " idle after"}, r.busy_after, 0);
    check({tag, " done single"}, r.done_after, 0);
    mdl_level = e_lvl;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[12];
    res_t r;
    int   kind, eff, delay;
    logic [1:0] algo;

    POWER_ON_RESET = 1'b1;
    cmd_reset_pulse = 0; cmd_zoom_in_pulse = 0; cmd_zoom_out_pulse = 0; cmd_return_pulse = 0;
    cmd_algorithm_select = 0; cmd_multiple_sw_error = 0; cmd_no_sw_error = 0;
    eng_if.eng_done = 0;
    repeat (3) step();
    check("reset level", controller_zoom_level, 3);
    check("reset target", eng_if.eng_target_level, 3);
    check("reset mode", eng_if.eng_mode, 0);
    check("reset done", controller_done, 0);
    check("reset error", cmd_error, 0);
    check("reset busy", busy, 0);
    check("reset start", eng_if.eng_start, 0);
    check("reset abort", eng_if.eng_abort, 0);
    POWER_ON_RESET = 1'b0;
    step();
    check("idle after reset", busy, 0);

    // kind algo nosw multi delay | start mode tgt err level
    vt[0]  = '{2, 2'b00, 0, 0,  0, 0, 0, 0, 1, 3};
    vt[1]  = '{1, 2'b00, 0, 0,  3, 1, 1, 4, 0, 4};
    vt[2]  = '{1, 2'b01, 0, 0,  0, 1, 2, 5, 0, 5};
    vt[3]  = '{1, 2'b00, 1, 0,  0, 0, 0, 0, 1, 5};
    vt[4]  = '{1, 2'b00, 0, 1,  0, 0, 0, 0, 1, 5};
    vt[5]  = '{1, 2'b10, 0, 0,  0, 0, 0, 0, 1, 5};
    vt[6]  = '{2, 2'b11, 0, 0,  1, 1, 4, 4, 0, 4};
    vt[7]  = '{2, 2'b10, 0, 0,  0, 1, 3, 3, 0, 3};
    vt[8]  = '{0, 2'b00, 0, 0,  0, 0, 0, 0, 0, 3};
    vt[9]  = '{1, 2'b00, 0, 0, -1, 1, 1, 4, 1, 3};
    vt[10] = '{2, 2'b10, 0, 0,  2, 1, 3, 2, 0, 2};
    vt[11] = '{0, 2'b11, 0, 0,  1, 1, 0, 3, 0, 3};
    for (int i = 0; i < 12; i++) begin
      run_cmd(vt[i].kind, vt[i].algo, vt[i].nosw, vt[i].multi, vt[i].delay, 1'b0, r);
      check($sformatf("vec%0d started", i), r.started, vt[i].exp_start);
      if (vt[i].exp_start != 0) begin
        check($sformatf("vec%0d mode", i), r.mode, vt[i].exp_mode);
        check($sformatf("vec%0d target", i), r.tgt, vt[i].exp_tgt);
        check($sformatf("vec%0d done cycle", i), r.done_k,
              (vt[i].delay < 0) ? TO + 1 : vt[i].delay + 2);
        check($sformatf("vec%0d abort cycle", i), r.abort_k, (vt[i].delay < 0) ? TO : -1);
      end else begin
        check($sformatf("vec%0d done cycle", i), r.done_k, 0);
      end
      check($sformatf("vec%0d error", i), r.err, vt[i].exp_err);
      check($sformatf("vec%0d level", i), r.level, vt[i].exp_level);
      check($sformatf("vec%0d idle after", i), r.busy_after, 0);
    end
    mdl_level = 3;

    // Climb to the top limit, then one more zoom_in must be refused.
    for (int i = 0; i < 3; i++) exec_model($sformatf("climb%0d", i), 1, 2'b00, 0, 0, i % 3, 0);
    check("level at max", controller_zoom_level, 6);
    run_cmd(1, 2'b01, 0, 0, 0, 0, r);
    check("over max started", r.started, 0);
    check("over max done cycle", r.done_k, 0);
    check("over max error", r.err, 1);
    check("over max level", r.level, 6);
    for (int i = 0; i < 6; i++) exec_model($sformatf("descend%0d", i), 2, 2'b11, 0, 0, 1, 0);
    check("level at min", controller_zoom_level, 0);
    exec_model("under min", 2, 2'b10, 0, 0, 0, 0);
    exec_model("return from min", 0, 2'b00, 0, 0, 1, 0);
    exec_model("up a", 1, 2'b00, 0, 0, 0, 0);
    exec_model("up b", 1, 2'b00, 0, 0, 0, 0);
    check("level before wait reset", controller_zoom_level, 5);

    // Operator reset while the engine is busy.
    step();
    cmd_algorithm_select = 2'b00;
    cmd_zoom_in_pulse = 1'b1;
    step();
    cmd_zoom_in_pulse = 1'b0;
    step();
    check("wait-reset start", eng_if.eng_start, 1);
    step();
    step();
    cmd_reset_pulse = 1'b1;
    #1;
    check("wait-reset abort", eng_if.eng_abort, 1);
    check("wait-reset no done", controller_done, 0);
    step();
    cmd_reset_pulse = 1'b0;
    #1;
    check("wait-reset level", controller_zoom_level, 3);
    check("wait-reset busy", busy, 0);
    check("wait-reset error", cmd_error, 0);
    check("wait-reset done", controller_done, 0);
    step();
    check("wait-reset done later", controller_done, 0);
    mdl_level = 3;

    // Coincident in/out strobes resolve to zoom_in; stray eng_done in IDLE is ignored.
    exec_model("in+out", 3, 2'b01, 0, 0, 2, 0);
    step();
    eng_if.eng_done = 1'b1;
    step();
    eng_if.eng_done = 1'b0;
    #1;
    check("stray done level", controller_zoom_level, 4);
    check("stray done busy", busy, 0);
    check("stray done pulse", controller_done, 0);
    exec_model("ret+in", 4, 2'b00, 0, 0, 0, 0);

    // Power-on reset mid-operation emits neither abort nor done.
    step();
    cmd_zoom_in_pulse = 1'b1;
    step();
    cmd_zoom_in_pulse = 1'b0;
    step();
    step();
    step();
    POWER_ON_RESET = 1'b1;
    #1;
    check("por abort", eng_if.eng_abort, 0);
    check("por done", controller_done, 0);
    check("por level", controller_zoom_level, 3);
    step();
    POWER_ON_RESET = 1'b0;
    #1;
    check("por busy", busy, 0);
    mdl_level = 3;

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 4);
      eff  = (kind == 3) ? 1 : (kind == 4) ? 0 : kind;
      algo = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && eff != 0) algo[1] = (eff == 2);
      delay = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 6);
      exec_model($sformatf("rnd%0d", n), kind, algo, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, delay, $urandom_range(0, 3) == 0);
    end

    // Reset strobe in IDLE clears a held error with no done pulse.
    exec_model("final reject", 1, 2'b10, 0, 0, 0, 0);
    step();
    cmd_reset_pulse = 1'b1;
    step();
    cmd_reset_pulse = 1'b0;
    #1;
    check("idle reset error", cmd_error, 0);
    check("idle reset level", controller_zoom_level, 3);
    check("idle reset done", controller_done, 0);
    check("idle reset busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
